// File: rtl/vop_pkg.sv
// Shared vop definitions used by the dual-lane decoder and the issue queue.
//   VOP_W     : width of a decoded vop code
//   NOP_VOP   : code that carries no work and is never stored
//   HOLD_VOP  : code that occupies the checker for two cycles
//   vop_t     : decoded vop code
//   entry_t   : queue entry, the vop plus the lane it arrived on
package vop_pkg;

  localparam int VOP_W = 4;

  typedef logic [VOP_W-1:0] vop_t;

  localparam vop_t NOP_VOP  = vop_t'(9);
  localparam vop_t HOLD_VOP = vop_t'(2);

  typedef struct packed {
    logic lane;
    vop_t vop;
  } entry_t;

  // A lane contributes an entry only when it is valid and not a NOP.
  function automatic logic vop_is_kept(input logic valid, input vop_t vop);
    return valid && (vop != NOP_VOP);
  endfunction

endpackage

// File: rtl/vop_issue_fsm.sv
// RUN/HOLD issue control for the vop issue queue.
// After a HOLD_VOP is handed to the checker the output is blanked for one
// cycle so the checker can finish its second cycle of work.
//   clk, reset      : clock, asynchronous active-low reset
//   flush_i         : synchronous clear, forces RUN and suppresses pop
//   has_entry_i     : queue holds at least one entry
//   head_is_hold_i  : head entry is a HOLD_VOP
//   out_ready_i     : checker accepts the head
//   out_valid_o     : head offered to the checker
//   pop_o           : head consumed on this edge
module vop_issue_fsm (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic has_entry_i,
  input  logic head_is_hold_i,
  input  logic out_ready_i,
  output logic out_valid_o,
  output logic pop_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_o = 1'b0;
    pop_o       = 1'b0;
    case (state_q)
      ST_RUN: begin
        out_valid_o = has_entry_i;
        // A flush discards the queue, so nothing is consumed that cycle.
        pop_o       = has_entry_i & out_ready_i & ~flush_i;
        if (pop_o && head_is_hold_i) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (flush_i) begin
      state_d = ST_RUN;
    end
  end

endmodule

// File: rtl/vop_issue_queue.sv
// Order-preserving 2-in/1-out issue queue between the dual-lane vop decoder
// and the single shared vop checker. NOPs are dropped on entry; kept vops are
// stored in program order (lane 0 before lane 1) in a circular buffer.
//   clk, reset  : clock, asynchronous active-low reset
//   flush       : synchronous clear of the queue contents
//   in_valid    : per-lane valid, bit 0 is lane 0 (older)
//   in_vops     : per-lane decoded vop codes
//   in_ready    : both lanes are accepted this cycle
//   out_valid   : head vop offered to the checker
//   out_vop     : head vop code
//   out_lane    : lane the head vop arrived on
//   out_ready   : checker accepts the head
//   occupancy   : current entry count
module vop_issue_queue
  import vop_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [1:0]                   in_valid,
  input  logic [1:0][VOP_W-1:0]        in_vops,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [VOP_W-1:0]             out_vop,
  output logic                         out_lane,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  entry_t mem_q [DEPTH];
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  cnt_t   count_q, count_d;

  logic [1:0] keep;
  logic [1:0] k;
  logic       push;
  logic       pop;
  cnt_t       free_slots;
  entry_t     wdata0, wdata1;
  ptr_t       waddr1;
  entry_t     head;

  assign keep[0] = vop_is_kept(in_valid[0], vop_t'(in_vops[0]));
  assign keep[1] = vop_is_kept(in_valid[1], vop_t'(in_vops[1]));
  assign k       = {1'b0, keep[0]} + {1'b0, keep[1]};

  // Readiness depends only on registered count so the front end never sees
  // a combinational path from its own valids; room for two is always demanded.
  assign free_slots = cnt_t'(DEPTH) - count_q;
  assign in_ready   = (free_slots >= cnt_t'(2)) & ~flush;
  assign push       = in_ready & (k != 2'd0);

  // The oldest kept lane always lands at wr_ptr; lane 1 follows only when
  // both lanes are kept.
  assign wdata0 = keep[0] ? '{lane: 1'b0, vop: vop_t'(in_vops[0])}
                          : '{lane: 1'b1, vop: vop_t'(in_vops[1])};
  assign wdata1 = '{lane: 1'b1, vop: vop_t'(in_vops[1])};
  assign waddr1 = wr_ptr_q + ptr_t'(1);

  assign head       = mem_q[rd_ptr_q];
  assign out_vop    = head.vop;
  assign out_lane   = head.lane;
  assign occupancy  = count_q;

  vop_issue_fsm u_fsm (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush),
    .has_entry_i    (count_q != cnt_t'(0)),
    .head_is_hold_i (head.vop == HOLD_VOP),
    .out_ready_i    (out_ready),
    .out_valid_o    (out_valid),
    .pop_o          (pop)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(k);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      count_d = count_q + (push ? cnt_t'(k) : cnt_t'(0)) - (pop ? cnt_t'(1) : cnt_t'(0));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is reset so out_vop/out_lane are never X while out_valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wdata0;
      if (keep == 2'b11) begin
        mem_q[waddr1] <= wdata1;
      end
    end
  end

endmodule

// File: tb/tb_vop_issue_queue.sv
module tb_vop_issue_queue;

  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][3:0]  in_vops;
  logic             in_ready;
  logic             out_valid;
  logic [3:0]       out_vop;
  logic             out_lane;
  logic             out_ready;
  logic [3:0]       occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of entries encoded lane*16 + vop, plus bubble flag.
  int expq[$];
  int popped[$];
  bit hold_m = 0;
  int peak = 0;

  vop_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_vops   (in_vops),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_vop   (out_vop),
    .out_lane  (out_lane),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compares the pre-edge outputs, then advances the
  // model by the edge that follows.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_occupancy", int'(occupancy), 0);
      chk("rst_in_ready", int'(in_ready), int'(!flush));
      expq.delete();
      hold_m = 0;
    end else begin
      int  sz;
      bit  exp_rdy, exp_vld, nxt_hold;
      int  e;
      sz      = expq.size();
      exp_rdy = ((DEPTH - sz) >= 2) && !flush;
      exp_vld = !hold_m && (sz > 0);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("out_valid", int'(out_valid), int'(exp_vld));
      chk("occupancy", int'(occupancy), sz);
      if (int'(occupancy) > peak) peak = int'(occupancy);
      if (exp_vld && out_valid) begin
        chk("head_vop", int'(out_vop), expq[0] % 16);
        chk("head_lane", int'(out_lane), expq[0] / 16);
      end
      nxt_hold = 0;
      if (flush) begin
        expq.delete();
      end else begin
        if (exp_vld && out_ready) begin
          e = expq.pop_front();
          popped.push_back(e);
          nxt_hold = ((e % 16) == 2);
        end
        if (exp_rdy) begin
          for (int i = 0; i < 2; i++) begin
            if (in_valid[i] && (int'(in_vops[i]) != 9)) expq.push_back(i * 16 + int'(in_vops[i]));
          end
        end
      end
      hold_m = nxt_hold;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input int v0, input int v1, input logic ordy);
    in_valid  = v;
    in_vops[0] = 4'(v0);
    in_vops[1] = 4'(v1);
    out_ready = ordy;
  endtask

  task automatic drain();
    int t;
    drive(2'b00, 0, 0, 1'b1);
    t = 0;
    while (occupancy != 0 && t < 200) begin
      step();
      t++;
    end
    step();
    chk("drain_done", int'(occupancy), 0);
  endtask

  initial begin
    int exp_seq[$];
    int vals[$];
    int idx;
    int t;

    reset = 0;
    flush = 0;
    drive(2'b00, 0, 0, 1'b0);
    repeat (3) step();
    reset = 1;
    repeat (2) step();
    @(negedge clk);
    chk("idle_out_valid", int'(out_valid), 0);
    chk("idle_occupancy", int'(occupancy), 0);
    chk("idle_in_ready", int'(in_ready), 1);

    // Order and NOP drop
    popped.delete();
    peak = 0;
    step();
    drive(2'b11, 1, 9, 1'b1);
    step();
    drive(2'b11, 4, 5, 1'b1);
    step();
    drive(2'b00, 0, 0, 1'b1);
    repeat (4) step();
    chk("order_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("order_0", popped[0], 1);
      chk("order_1", popped[1], 4);
      chk("order_2", popped[2], 16 + 5);
    end
    chk("order_peak", peak, 2);

    // Fill and back-pressure
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 3, 4, 1'b0);
      step();
    end
    drive(2'b00, 0, 0, 1'b0);
    @(negedge clk);
    chk("fill_occ", int'(occupancy), 8);
    chk("fill_rdy", int'(in_ready), 0);
    step();
    out_ready = 1;
    step();
    out_ready = 0;
    @(negedge clk);
    chk("pop1_occ", int'(occupancy), 7);
    chk("pop1_rdy", int'(in_ready), 0);
    step();
    out_ready = 1;
    step();
    out_ready = 0;
    @(negedge clk);
    chk("pop2_occ", int'(occupancy), 6);
    chk("pop2_rdy", int'(in_ready), 1);
    drain();

    // Hold bubble
    drive(2'b11, 2, 0, 1'b0);
    step();
    drive(2'b00, 0, 0, 1'b1);
    @(negedge clk);
    chk("hold_n_vld", int'(out_valid), 1);
    chk("hold_n_vop", int'(out_vop), 2);
    step();
    @(negedge clk);
    chk("hold_n1_vld", int'(out_valid), 0);
    chk("hold_n1_occ", int'(occupancy), 1);
    step();
    @(negedge clk);
    chk("hold_n2_vld", int'(out_valid), 1);
    chk("hold_n2_vop", int'(out_vop), 0);
    step();
    drain();

    // Flush with simultaneous traffic
    drive(2'b11, 5, 6, 1'b0);
    step();
    drive(2'b11, 7, 8, 1'b0);
    step();
    drive(2'b01, 1, 0, 1'b0);
    step();
    drive(2'b00, 0, 0, 1'b0);
    @(negedge clk);
    chk("preflush_occ", int'(occupancy), 5);
    step();
    flush = 1;
    drive(2'b11, 3, 4, 1'b1);
    @(negedge clk);
    chk("flush_rdy", int'(in_ready), 0);
    step();
    flush = 0;
    drive(2'b00, 0, 0, 1'b1);
    @(negedge clk);
    chk("postflush_occ", int'(occupancy), 0);
    chk("postflush_vld", int'(out_valid), 0);
    step();

    // Pointer wrap: 20 single vops with out_ready toggling
    vals.delete();
    exp_seq.delete();
    for (int v = 0; v < 14; v++) if (v != 9) vals.push_back(v);
    for (int i = 0; i < 20; i++) exp_seq.push_back(vals[i % vals.size()]);
    popped.delete();
    idx = 0;
    t = 0;
    while (idx < 20 && t < 400) begin
      drive(2'b01, exp_seq[idx], 0, 1'(t % 2));
      @(negedge clk);
      if (in_ready) idx++;
      step();
      t++;
    end
    drain();
    chk("wrap_count", popped.size(), 20);
    for (int i = 0; i < 20 && i < popped.size(); i++) chk("wrap_order", popped[i], exp_seq[i]);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int r0, r1;
      r0 = ($urandom_range(0, 3) == 0) ? 9 : (($urandom_range(0, 4) == 0) ? 2 : int'($urandom_range(0, 15)));
      r1 = ($urandom_range(0, 3) == 0) ? 9 : (($urandom_range(0, 4) == 0) ? 2 : int'($urandom_range(0, 15)));
      drive(2'($urandom_range(0, 3)), r0, r1, 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 63) == 0);
      if (i == 1000) reset = 0;
      if (i == 1003) reset = 1;
      step();
    end
    flush = 0;
    drain();

    // Reset while full
    drive(2'b11, 1, 3, 1'b0);
    repeat (5) step();
    #2 reset = 0;
    #1;
    chk("async_rst_occ", int'(occupancy), 0);
    chk("async_rst_vld", int'(out_valid), 0);
    step();
    reset = 1;
    drive(2'b00, 0, 0, 1'b1);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
